// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg: states, LCD commands and message ROM; defining LCD_CLEAR_EN appends the clear command to init
package lcd_ctrl_pkg;
  typedef enum logic [2:0] {PWR_WAIT, SETUP, E_HIGH, HOLD, DONE} state_t;
  localparam int CNT_W = 8;
  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON = 8'h0C;
  localparam logic [7:0] CMD_ENTRY = 8'h06;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
`ifdef LCD_CLEAR_EN
  localparam logic [3:0] INIT_LEN = 4'd4;
`else
  localparam logic [3:0] INIT_LEN = 4'd3;
`endif
  localparam logic [3:0] MSG_LEN = 4'd5;
  localparam logic [39:0] MSG_ROM = {8'h4F, 8'h4C, 8'h4C, 8'h45, 8'h48};
  function automatic logic [7:0] init_cmd(input logic [3:0] i);
    return i == 4'd0 ? CMD_FUNC_SET : i == 4'd1 ? CMD_DISP_ON : i == 4'd2 ? CMD_ENTRY : CMD_CLEAR;
  endfunction
  function automatic logic [7:0] msg_char(input logic [3:0] i);
    return MSG_ROM[{i, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/lcd_delay_counter.sv
// lcd_delay_counter: loadable down-counter, count_done in the last cycle of each timed interval
module lcd_delay_counter
  import lcd_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] len,
  output logic             count_done
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (en && cnt == '0) ? len - 1'b1 : cnt != '0 ? cnt - 1'b1 : cnt;
  assign count_done = cnt == CNT_W'(1);
endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780-style init then "HELLO" writer; LCD_CLEAR_EN adds the 0x01 clear command to init
module lcd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int PWR_CYCLES        = 8,
  parameter int E_CYCLES          = 2,
  parameter int WAIT_CYCLES       = 4,
  parameter int CLEAR_WAIT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] data,
  output logic       lcd_e,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic       count_done,
  output logic       init_done,
  output logic [3:0] current_count
);
  state_t           state, state_nx;
  logic [3:0]       count_nx;
  logic             init_done_nx, timed, last;
  logic [CNT_W-1:0] len;
  logic [7:0]       byte_nx;
  assign lcd_rw = 1'b0;
  always_comb begin
    timed = state inside {PWR_WAIT, E_HIGH, HOLD};
    len = state == PWR_WAIT ? CNT_W'(PWR_CYCLES) :
          state == E_HIGH ? CNT_W'(E_CYCLES) :
          (!lcd_rs && data == CMD_CLEAR) ? CNT_W'(CLEAR_WAIT_CYCLES) : CNT_W'(WAIT_CYCLES);
    last = current_count == (init_done ? MSG_LEN : INIT_LEN) - 4'd1;
    state_nx = state;
    count_nx = current_count;
    init_done_nx = init_done;
    case (state)
      PWR_WAIT: state_nx = count_done ? SETUP : PWR_WAIT;
      SETUP:    state_nx = E_HIGH;
      E_HIGH:   state_nx = count_done ? HOLD : E_HIGH;
      HOLD:
        if (count_done) begin
          state_nx = (last && init_done) ? DONE : SETUP;
          count_nx = last ? (init_done ? current_count : 4'd0) : current_count + 4'd1;
          init_done_nx = init_done | last;
        end
      default: state_nx = state;
    endcase
    byte_nx = init_done_nx ? msg_char(count_nx) : init_cmd(count_nx);
  end
  lcd_delay_counter u_delay (
    .clk        (clk),
    .rst        (rst),
    .en         (timed),
    .len        (len),
    .count_done (count_done)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= PWR_WAIT;
      data <= '0;
      lcd_e <= 1'b0;
      lcd_rs <= 1'b0;
      init_done <= 1'b0;
      current_count <= '0;
    end else begin
      state <= state_nx;
      current_count <= count_nx;
      init_done <= init_done_nx;
      lcd_e <= state_nx == E_HIGH;
      data <= state_nx == SETUP ? byte_nx : data;
      lcd_rs <= state_nx == SETUP ? init_done_nx : lcd_rs;
    end
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: table-driven scoreboard bench for lcd_ctrl
module tb_lcd_ctrl;
  localparam int PW = 8, EC = 2, WC = 4, CW = 8;
`ifdef LCD_CLEAR_EN
  localparam int NI = 4;
`else
  localparam int NI = 3;
`endif
  localparam int INIT_EDGES = PW + 3 * (1 + EC + WC) + (NI == 4 ? 1 + EC + CW : 0);
  localparam int DONE_EDGES = INIT_EDGES + 5 * (1 + EC + WC);
  typedef struct {
    logic [7:0] data;
    logic       rs;
    logic [3:0] cnt;
    logic       idone;
    int         hold;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] data;
  logic lcd_e, lcd_rw, lcd_rs, count_done, init_done;
  logic [3:0] current_count;
  vec_t tbl[9];
  vec_t q[$];
  vec_t cur;
  logic [7:0] ic[4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
  logic [7:0] msg[5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
  int ntbl = 0, checks = 0, errors = 0, cyc = 0;
  int hi_len = 0, fall_cyc = -1, prev_hold = 0, first_cd = -1, first_id = -1;
  logic prev_e = 1'b0, have_cur = 1'b0, seen_clear = 1'b0;

  lcd_ctrl #(.PWR_CYCLES(PW), .E_CYCLES(EC), .WAIT_CYCLES(WC), .CLEAR_WAIT_CYCLES(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .data          (data),
    .lcd_e         (lcd_e),
    .lcd_rw        (lcd_rw),
    .lcd_rs        (lcd_rs),
    .count_done    (count_done),
    .init_done     (init_done),
    .current_count (current_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load_q();
    q.delete();
    for (int i = 0; i < ntbl; i++) q.push_back(tbl[i]);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev_e = 1'b0;
      hi_len = 0;
      fall_cyc = -1;
      have_cur = 1'b0;
      first_cd = -1;
      first_id = -1;
    end else begin
      if (!lcd_rs && data == 8'h01) seen_clear = 1'b1;
      if (count_done && first_cd < 0) first_cd = cyc;
      if (init_done && first_id < 0) first_id = cyc;
      if (lcd_e && !prev_e) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          have_cur = 1'b0;
          $display("FAIL extra_pulse: got data %0h with no transfer expected (t=%0t)", data, $time);
        end else begin
          cur = q.pop_front();
          have_cur = 1'b1;
          chk("pulse_data", data, cur.data);
          chk("pulse_rs", lcd_rs, cur.rs);
          chk("pulse_count", current_count, cur.cnt);
          chk("pulse_init_done", init_done, cur.idone);
          chk("pulse_rw", lcd_rw, 0);
          if (fall_cyc < 0) chk("first_rise_edge", cyc, PW + 1);
          else chk("hold_gap", cyc - fall_cyc, prev_hold + 1);
        end
        hi_len = 1;
      end else if (lcd_e) begin
        hi_len++;
        if (have_cur) chk("e_high_data", data, cur.data);
      end else if (prev_e && have_cur) begin
        chk("e_len", hi_len, EC);
        chk("hold_data", data, cur.data);
        chk("hold_rs", lcd_rs, cur.rs);
        fall_cyc = cyc;
        prev_hold = cur.hold;
      end
      prev_e = lcd_e;
    end
  end

  task automatic run_to_done();
    int g = 0;
    while (cyc < DONE_EDGES - 1 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("last_hold_count_done", count_done, 1);
    chk("last_hold_count", current_count, 4);
    @(negedge clk);
    chk("done_edge", cyc, DONE_EDGES);
    chk("done_count_done", count_done, 0);
    chk("first_count_done_edge", first_cd, PW - 1);
    chk("init_done_edge", first_id, INIT_EDGES);
    chk("all_transfers_seen", q.size(), 0);
    repeat (20) @(negedge clk);
    chk("done_e", lcd_e, 0);
    chk("done_data", data, 8'h4F);
    chk("done_rs", lcd_rs, 1);
    chk("done_rw", lcd_rw, 0);
    chk("done_count", current_count, 4);
    chk("done_init_done", init_done, 1);
    chk("done_hold_count_done", count_done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NI; i++) tbl[ntbl++] = '{ic[i], 1'b0, 4'(i), 1'b0, i == 3 ? CW : WC};
    for (int i = 0; i < 5; i++) tbl[ntbl++] = '{msg[i], 1'b1, 4'(i), 1'b1, WC};
    #7;
    chk("rst_data", data, 0);
    chk("rst_e", lcd_e, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_count_done", count_done, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_count", current_count, 0);
    load_q();
    #3 rst = 1'b1;
    run_to_done();
    chk("clear_cmd_seen", seen_clear, NI == 4);
    #3 rst = 1'b0;
    load_q();
    #20 rst = 1'b1;
    for (int g = 0; g < 100 && !lcd_e; g++) @(negedge clk);
    chk("mid_pulse_reached", lcd_e, 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_e", lcd_e, 0);
    chk("abort_data", data, 0);
    chk("abort_rs", lcd_rs, 0);
    chk("abort_count", current_count, 0);
    chk("abort_count_done", count_done, 0);
    chk("abort_init_done", init_done, 0);
    #19 load_q();
    #1 rst = 1'b1;
    run_to_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
